// File: rtl/bank_ctrl_pkg.sv
// Shared types and helpers for the per-bank DRAM command controller.
//   cmd_e        : command codes carried on the cmd input
//   bank_state_e : per-bank controller states
//   cnt_width()  : width of the shared per-bank latency/burst down-counter
package bank_ctrl_pkg;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    ACT  = 3'd1,
    RD   = 3'd2,
    WR   = 3'd3,
    PRE  = 3'd4,
    PREA = 3'd5
  } cmd_e;

  typedef enum logic [2:0] {
    StIdle,
    StActivating,
    StActive,
    StRdWait,
    StWrWait,
    StBurst,
    StPrecharging
  } bank_state_e;

  function automatic int unsigned max_of5(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d,
                                          input int unsigned e);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

  // One counter per bank serves every timer, so it must hold the largest of them.
  function automatic int unsigned cnt_width(input int unsigned trcd, input int unsigned trp,
                                            input int unsigned tcl, input int unsigned tcwl,
                                            input int unsigned bl);
    return $clog2(max_of5(trcd, trp, tcl, tcwl, bl) + 1);
  endfunction

endpackage

// File: rtl/bank_fsm.sv
// One DRAM bank: state machine, ACT/PRE/RD/WR latency timer and burst column walker.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   hit           : a bank command (ACT/RD/WR/PRE) addressed to this bank this cycle
//   cmd           : command code (cmd_e)
//   cmd_row       : row for ACT
//   cmd_col       : start column for RD/WR
//   prea          : an accepted precharge-all this cycle
//   rd_o_wr       : 0=read, 1=write (direction of last access)
//   row           : open row
//   column        : column of the current data beat
//   burst_active  : high on each data beat
//   busy          : bank is activating, waiting for data or bursting (blocks PREA)
//   illegal       : the command hitting this bank is not allowed in the current state
module bank_fsm
  import bank_ctrl_pkg::*;
#(
  parameter int unsigned COLWIDTH = 10,
  parameter int unsigned CHWIDTH  = 5,
  parameter int unsigned BL       = 8,
  parameter int unsigned TRCD     = 4,
  parameter int unsigned TRP      = 4,
  parameter int unsigned TCL      = 5,
  parameter int unsigned TCWL     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hit,
  input  logic [2:0]          cmd,
  input  logic [CHWIDTH-1:0]  cmd_row,
  input  logic [COLWIDTH-1:0] cmd_col,
  input  logic                prea,
  output logic                rd_o_wr,
  output logic [CHWIDTH-1:0]  row,
  output logic [COLWIDTH-1:0] column,
  output logic                burst_active,
  output logic                busy,
  output logic                illegal
);

  localparam int unsigned CntW = cnt_width(TRCD, TRP, TCL, TCWL, BL);
  localparam logic [COLWIDTH-1:0] BeatMask = COLWIDTH'(BL - 1);
  // Wait states last lat-1 cycles so the next state is visible on edge T+lat.
  localparam logic [CntW-1:0] TrcdLoad  = CntW'(TRCD - 1);
  localparam logic [CntW-1:0] TrpLoad   = CntW'(TRP - 1);
  localparam logic [CntW-1:0] TclLoad   = CntW'(TCL - 1);
  localparam logic [CntW-1:0] TcwlLoad  = CntW'(TCWL - 1);
  localparam logic [CntW-1:0] BurstLoad = CntW'(BL - 1);

  bank_state_e          state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [CHWIDTH-1:0]   row_q, row_d;
  logic [COLWIDTH-1:0]  col_q, col_d;
  logic                 wr_q, wr_d;
  logic                 is_wr;
  logic                 lat_one;
  logic                 wait_done;

  assign is_wr     = (cmd == WR);
  assign lat_one   = is_wr ? (TCWL == 1) : (TCL == 1);
  assign wait_done = (cnt_q <= CntW'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    wr_d    = wr_q;
    illegal = 1'b0;

    case (state_q)
      StIdle: begin
        if (hit) begin
          case (cmd)
            ACT: begin
              row_d = cmd_row;
              if (TRCD == 1) begin
                state_d = StActive;
              end else begin
                state_d = StActivating;
                cnt_d   = TrcdLoad;
              end
            end
            RD, WR:  illegal = 1'b1;
            default: ;  // PRE on an idle bank is a harmless no-op
          endcase
        end
      end

      StActive: begin
        if (hit) begin
          case (cmd)
            RD, WR: begin
              wr_d  = is_wr;
              col_d = cmd_col;
              if (lat_one) begin
                state_d = StBurst;
                cnt_d   = BurstLoad;
              end else begin
                state_d = is_wr ? StWrWait : StRdWait;
                cnt_d   = is_wr ? TcwlLoad : TclLoad;
              end
            end
            PRE: begin
              if (TRP == 1) begin
                state_d = StIdle;
              end else begin
                state_d = StPrecharging;
                cnt_d   = TrpLoad;
              end
            end
            default: illegal = 1'b1;
          endcase
        end else if (prea) begin
          if (TRP == 1) begin
            state_d = StIdle;
          end else begin
            state_d = StPrecharging;
            cnt_d   = TrpLoad;
          end
        end
      end

      StActivating, StPrecharging: begin
        illegal = hit;
        if (wait_done) begin
          state_d = (state_q == StActivating) ? StActive : StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StRdWait, StWrWait: begin
        illegal = hit;
        if (wait_done) begin
          state_d = StBurst;
          cnt_d   = BurstLoad;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StBurst: begin
        illegal = hit;
        if (cnt_q == '0) begin
          state_d = StActive;
        end else begin
          cnt_d = cnt_q - CntW'(1);
          // Wrap within the burst-aligned block; upper column bits stay fixed.
          col_d = (col_q & ~BeatMask) | ((col_q + COLWIDTH'(1)) & BeatMask);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
      wr_q    <= wr_d;
    end
  end

  assign rd_o_wr      = wr_q;
  assign row          = row_q;
  assign column       = col_q;
  assign burst_active = (state_q == StBurst);
  assign busy         = (state_q == StActivating) || (state_q == StRdWait) ||
                        (state_q == StWrWait) || (state_q == StBurst);

endmodule

// File: rtl/bank_cmd_ctrl.sv
// Per-bank command/timing controller feeding the Chip model.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   cmd_valid     : command present this cycle
//   cmd           : command code (cmd_e)
//   cmd_bg/cmd_ba : target bank group / bank
//   cmd_row       : row for ACT
//   cmd_col       : column for RD/WR
//   cmd_err       : one-cycle pulse, previous command was illegal and dropped
//   rd_o_wr       : per bank, 0=read 1=write
//   row           : per bank, open row
//   column        : per bank, current beat column
//   burst_active  : per bank, high on each data beat
module bank_cmd_ctrl
  import bank_ctrl_pkg::*;
#(
  parameter int unsigned BGWIDTH  = 2,
  parameter int unsigned BAWIDTH  = 2,
  parameter int unsigned COLWIDTH = 10,
  parameter int unsigned CHWIDTH  = 5,
  parameter int unsigned BL       = 8,
  parameter int unsigned TRCD     = 4,
  parameter int unsigned TRP      = 4,
  parameter int unsigned TCL      = 5,
  parameter int unsigned TCWL     = 4,
  localparam int unsigned BANKGROUPS    = 1 << BGWIDTH,
  localparam int unsigned BANKSPERGROUP = 1 << BAWIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  input  logic [2:0]          cmd,
  input  logic [BGWIDTH-1:0]  cmd_bg,
  input  logic [BAWIDTH-1:0]  cmd_ba,
  input  logic [CHWIDTH-1:0]  cmd_row,
  input  logic [COLWIDTH-1:0] cmd_col,
  output logic                cmd_err,
  output logic                rd_o_wr      [BANKGROUPS][BANKSPERGROUP],
  output logic [CHWIDTH-1:0]  row          [BANKGROUPS][BANKSPERGROUP],
  output logic [COLWIDTH-1:0] column       [BANKGROUPS][BANKSPERGROUP],
  output logic                burst_active [BANKGROUPS][BANKSPERGROUP]
);

  localparam int unsigned NumBanks = BANKGROUPS * BANKSPERGROUP;

  logic                bank_cmd;
  logic                prea_req;
  logic                unknown_cmd;
  logic                prea_go;
  logic                err_d;
  logic                cmd_err_q;
  logic [NumBanks-1:0] illegal_vec;
  logic [NumBanks-1:0] busy_vec;

  always_comb begin
    bank_cmd    = 1'b0;
    prea_req    = 1'b0;
    unknown_cmd = 1'b0;
    if (cmd_valid) begin
      case (cmd)
        ACT, RD, WR, PRE: bank_cmd    = 1'b1;
        PREA:             prea_req    = 1'b1;
        NOP:              ;
        default:          unknown_cmd = 1'b1;
      endcase
    end
  end

  // PREA is all-or-nothing: a single busy bank vetoes it for every bank.
  assign prea_go = prea_req && !(|busy_vec);
  assign err_d   = (|illegal_vec) || unknown_cmd || (prea_req && (|busy_vec));

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_err_q <= 1'b0;
    end else begin
      cmd_err_q <= err_d;
    end
  end

  assign cmd_err = cmd_err_q;

  for (genvar g = 0; g < BANKGROUPS; g++) begin : g_grp
    for (genvar b = 0; b < BANKSPERGROUP; b++) begin : g_bank
      logic hit;
      assign hit = bank_cmd && (cmd_bg == BGWIDTH'(g)) && (cmd_ba == BAWIDTH'(b));

      bank_fsm #(
        .COLWIDTH (COLWIDTH),
        .CHWIDTH  (CHWIDTH),
        .BL       (BL),
        .TRCD     (TRCD),
        .TRP      (TRP),
        .TCL      (TCL),
        .TCWL     (TCWL)
      ) u_bank (
        .clk          (clk),
        .rst          (rst),
        .hit          (hit),
        .cmd          (cmd),
        .cmd_row      (cmd_row),
        .cmd_col      (cmd_col),
        .prea         (prea_go),
        .rd_o_wr      (rd_o_wr[g][b]),
        .row          (row[g][b]),
        .column       (column[g][b]),
        .burst_active (burst_active[g][b]),
        .busy         (busy_vec[g*BANKSPERGROUP+b]),
        .illegal      (illegal_vec[g*BANKSPERGROUP+b])
      );
    end
  end

endmodule

// File: tb/tb_bank_cmd_ctrl.sv
// Bench for bank_cmd_ctrl: timestamp-based bank model checked every cycle, plus
// hand-computed literal expectations along the directed sequence.
module tb_bank_cmd_ctrl;
  import bank_ctrl_pkg::*;

  localparam int BL   = 8;
  localparam int TRCD = 4;
  localparam int TRP  = 4;
  localparam int TCL  = 5;
  localparam int TCWL = 4;
  localparam int NB   = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd = 3'd0;
  logic [1:0] cmd_bg = '0;
  logic [1:0] cmd_ba = '0;
  logic [4:0] cmd_row = '0;
  logic [9:0] cmd_col = '0;
  logic       cmd_err;
  logic       rd_o_wr      [4][4];
  logic [4:0] row          [4][4];
  logic [9:0] column       [4][4];
  logic       burst_active [4][4];

  bank_cmd_ctrl #(
    .BGWIDTH (2), .BAWIDTH (2), .COLWIDTH (10), .CHWIDTH (5),
    .BL (BL), .TRCD (TRCD), .TRP (TRP), .TCL (TCL), .TCWL (TCWL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd          (cmd),
    .cmd_bg       (cmd_bg),
    .cmd_ba       (cmd_ba),
    .cmd_row      (cmd_row),
    .cmd_col      (cmd_col),
    .cmd_err      (cmd_err),
    .rd_o_wr      (rd_o_wr),
    .row          (row),
    .column       (column),
    .burst_active (burst_active)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Model: a bank is open or closed, and accepts nothing before m_ready.
  longint     edge_n = 0;
  bit         m_open   [NB];
  longint     m_ready  [NB];
  longint     m_bstart [NB];
  logic [4:0] m_row    [NB];
  logic [9:0] m_col    [NB];
  bit         m_wr     [NB];
  bit         exp_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NB; i++) begin
      m_open[i] = 1'b0; m_ready[i] = 0; m_bstart[i] = 64'd1000000000;
      m_row[i] = '0; m_col[i] = '0; m_wr[i] = 1'b0;
    end
    exp_err = 1'b0;
  endfunction

  initial model_reset();

  always @(posedge clk) begin
    longint e;
    int     idx;
    int     lat;
    bit     err;
    bit     any_busy;
    edge_n++;
    e   = edge_n;
    idx = int'(cmd_bg) * 4 + int'(cmd_ba);
    err = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      if (cmd_valid) begin
        case (cmd)
          NOP: ;
          ACT: begin
            if (!m_open[idx] && e >= m_ready[idx]) begin
              m_open[idx] = 1'b1; m_ready[idx] = e + TRCD; m_row[idx] = cmd_row;
            end else err = 1'b1;
          end
          RD, WR: begin
            if (m_open[idx] && e >= m_ready[idx]) begin
              lat = (cmd == WR) ? TCWL : TCL;
              m_wr[idx] = (cmd == WR); m_col[idx] = cmd_col;
              m_bstart[idx] = e + lat; m_ready[idx] = e + lat + BL;
            end else err = 1'b1;
          end
          PRE: begin
            if (e < m_ready[idx]) err = 1'b1;
            else if (m_open[idx]) begin
              m_open[idx] = 1'b0; m_ready[idx] = e + TRP;
            end
          end
          PREA: begin
            any_busy = 1'b0;
            for (int i = 0; i < NB; i++) if (m_open[i] && e < m_ready[i]) any_busy = 1'b1;
            if (any_busy) err = 1'b1;
            else for (int i = 0; i < NB; i++)
              if (m_open[i]) begin m_open[i] = 1'b0; m_ready[i] = e + TRP; end
          end
          default: err = 1'b1;
        endcase
      end
      exp_err = err;
    end
  end

  // Outputs seen after edge e are those the spec labels cycle e+1.
  always @(negedge clk) begin
    longint s;
    longint beat;
    int     i;
    logic   eb;
    logic [9:0] ec;
    if (chk_en) begin
      s = edge_n + 1;
      check("cmd_err", cmd_err, exp_err);
      for (int g = 0; g < 4; g++) begin
        for (int b = 0; b < 4; b++) begin
          i = g * 4 + b;
          eb = (s >= m_bstart[i]) && (s < m_bstart[i] + BL);
          if (s < m_bstart[i]) beat = 0;
          else if (s - m_bstart[i] >= BL) beat = BL - 1;
          else beat = s - m_bstart[i];
          ec = (m_col[i] & ~10'(BL - 1)) | ((m_col[i] + 10'(beat)) & 10'(BL - 1));
          check($sformatf("bank %0d/%0d {burst,wr,row,col}", g, b),
                {burst_active[g][b], rd_o_wr[g][b], row[g][b], column[g][b]},
                {eb, m_wr[i], m_row[i], ec});
        end
      end
    end
  end

  task automatic sample_at(input longint x);
    while (edge_n < x - 1) @(negedge clk);
  endtask

  task automatic issue_at(input longint x, input logic [2:0] c, input int bg, input int ba,
                          input logic [4:0] r, input logic [9:0] col);
    sample_at(x);
    check("issue schedule", edge_n, x - 1);
    cmd_valid = 1'b1; cmd = c; cmd_bg = 2'(bg); cmd_ba = 2'(ba); cmd_row = r; cmd_col = col;
    @(negedge clk);
    cmd_valid = 1'b0; cmd = NOP;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    longint t0, t1, a, t3, p, aa, bb;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset row[1][2]", row[1][2], 5'd0);
    check("reset burst[3][3]", burst_active[3][3], 1'b0);
    check("reset cmd_err", cmd_err, 1'b0);

    // 1: ACT then too-early RD, then on-time RD
    t0 = edge_n + 2;
    issue_at(t0, ACT, 1, 2, 5'h11, 10'h0);
    sample_at(t0 + 1);
    check("act row[1][2]", row[1][2], 5'h11);
    issue_at(t0 + 3, RD, 1, 2, 5'h0, 10'h3FE);
    sample_at(t0 + 4);
    check("early rd err", cmd_err, 1'b1);
    t1 = t0 + 4;
    issue_at(t1, RD, 1, 2, 5'h0, 10'h3FE);
    sample_at(t1 + 1);
    check("rd accepted no err", cmd_err, 1'b0);

    // 2: read burst with column wrap
    sample_at(t1 + 4);
    check("rd burst before", burst_active[1][2], 1'b0);
    sample_at(t1 + 5);
    check("rd beat0 burst", burst_active[1][2], 1'b1);
    check("rd beat0 col", column[1][2], 10'h3FE);
    check("rd dir", rd_o_wr[1][2], 1'b0);
    sample_at(t1 + 6);
    check("rd beat1 col", column[1][2], 10'h3FF);
    sample_at(t1 + 7);
    check("rd beat2 col", column[1][2], 10'h3F8);
    sample_at(t1 + 12);
    check("rd beat7 col", column[1][2], 10'h3FD);
    check("rd beat7 burst", burst_active[1][2], 1'b1);
    sample_at(t1 + 13);
    check("rd burst after", burst_active[1][2], 1'b0);

    // 3: write burst on bank 0/0, 4: PRE during burst and PRE timing
    a = t1 + 14;
    issue_at(a, ACT, 0, 0, 5'h03, 10'h0);
    t3 = a + 4;
    issue_at(t3, WR, 0, 0, 5'h0, 10'h010);
    sample_at(t3 + 3);
    check("wr burst before", burst_active[0][0], 1'b0);
    sample_at(t3 + 4);
    check("wr beat0 burst", burst_active[0][0], 1'b1);
    check("wr beat0 col", column[0][0], 10'h010);
    check("wr dir", rd_o_wr[0][0], 1'b1);
    issue_at(t3 + 5, PRE, 0, 0, 5'h0, 10'h0);
    sample_at(t3 + 6);
    check("pre in burst err", cmd_err, 1'b1);
    check("wr beat2 col", column[0][0], 10'h012);
    sample_at(t3 + 11);
    check("wr beat7 col", column[0][0], 10'h017);
    sample_at(t3 + 12);
    check("wr burst after", burst_active[0][0], 1'b0);
    p = t3 + 12;
    issue_at(p, PRE, 0, 0, 5'h0, 10'h0);
    issue_at(p + 3, ACT, 0, 0, 5'h0A, 10'h0);
    sample_at(p + 4);
    check("early act err", cmd_err, 1'b1);
    issue_at(p + 4, ACT, 0, 0, 5'h0A, 10'h0);
    sample_at(p + 5);
    check("act after trp no err", cmd_err, 1'b0);
    check("act row[0][0]", row[0][0], 5'h0A);

    // 5: overlapping bursts in two banks, PREA blocked then accepted
    aa = p + 5;
    issue_at(aa, ACT, 3, 3, 5'h1F, 10'h0);
    issue_at(aa + 4, RD, 3, 3, 5'h0, 10'h005);
    issue_at(aa + 5, RD, 0, 0, 5'h0, 10'h0FF);
    sample_at(aa + 11);
    check("ovl 3/3 col", column[3][3], 10'h007);
    check("ovl 0/0 col", column[0][0], 10'h0F8);
    check("ovl both bursting", {burst_active[3][3], burst_active[0][0]}, 2'b11);
    issue_at(aa + 12, PREA, 0, 0, 5'h0, 10'h0);
    sample_at(aa + 13);
    check("prea busy err", cmd_err, 1'b1);
    issue_at(aa + 18, PREA, 0, 0, 5'h0, 10'h0);
    sample_at(aa + 19);
    check("prea ok no err", cmd_err, 1'b0);
    issue_at(aa + 19, 3'd6, 0, 0, 5'h0, 10'h0);
    sample_at(aa + 20);
    check("unknown cmd err", cmd_err, 1'b1);
    issue_at(aa + 20, PRE, 2, 0, 5'h0, 10'h0);
    sample_at(aa + 21);
    check("pre idle no err", cmd_err, 1'b0);
    issue_at(aa + 21, PRE, 0, 0, 5'h0, 10'h0);
    sample_at(aa + 22);
    check("pre precharging err", cmd_err, 1'b1);
    issue_at(aa + 22, NOP, 1, 1, 5'h0, 10'h0);
    sample_at(aa + 23);
    check("nop no err", cmd_err, 1'b0);

    // 6: reset in the middle of a burst
    bb = aa + 26;
    issue_at(bb, ACT, 2, 1, 5'h05, 10'h0);
    issue_at(bb + 4, RD, 2, 1, 5'h0, 10'h100);
    sample_at(bb + 11);
    check("pre-reset burst", burst_active[2][1], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("post-reset burst", burst_active[2][1], 1'b0);
    check("post-reset row", row[2][1], 5'h00);
    check("post-reset col", column[2][1], 10'h000);
    issue_at(bb + 12, ACT, 2, 1, 5'h07, 10'h0);
    sample_at(bb + 13);
    check("act after reset no err", cmd_err, 1'b0);
    check("act after reset row", row[2][1], 5'h07);
    issue_at(bb + 13, ACT, 2, 1, 5'h09, 10'h0);
    sample_at(bb + 14);
    check("act while activating err", cmd_err, 1'b1);
    check("row held", row[2][1], 5'h07);

    repeat (4) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
